// File: rtl/mem_arb_pkg.sv
// Shared defaults and command record for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW    = 6;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic              wr;
        logic [DEF_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout while not empty.
module cmd_fifo
    import mem_arb_pkg::*;
#(
    parameter type T     = mem_cmd_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = DEPTH[PW:0];

    T               mem_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push_ok && !pop_ok)
                count_reg <= count_reg + CNT_ONE;
            else if (pop_ok && !push_ok)
                count_reg <= count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= din;
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == CNT_MAX);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto a single registered memory port,
// returning read data to the requester that issued the read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic          req0_wr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic          req1_wr,
    input  logic [DW-1:0] req1_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic          mem_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t          push_cmd [2];
    cmd_t          head_cmd [2];
    logic [1:0]    push_valid;
    logic [1:0]    fifo_full;
    logic [1:0]    fifo_empty;
    logic [1:0]    fifo_pop;

    logic          grant_valid;
    logic          grant_id;
    cmd_t          grant_cmd;

    logic          rr_ptr_reg;
    logic          mem_en_reg;
    logic [AW-1:0] mem_addr_reg;
    logic          mem_wr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic          mem_id_reg;
    logic          rsp_valid_reg;
    logic          rsp_id_reg;

    assign push_cmd[0] = {req0_addr, req0_wr, req0_wdata};
    assign push_cmd[1] = {req1_addr, req1_wr, req1_wdata};
    assign push_valid  = {req1_valid, req0_valid};
    assign req0_ready  = !fifo_full[0];
    assign req1_ready  = !fifo_full[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            cmd_fifo #(
                .T     (cmd_t),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push_valid[gi]),
                .din   (push_cmd[gi]),
                .pop   (fifo_pop[gi]),
                .dout  (head_cmd[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi])
            );
        end
    endgenerate

    // rr_ptr only breaks ties; a lone non-empty FIFO is always served.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!fifo_empty[0] && !fifo_empty[1]) begin
            grant_valid = 1'b1;
            grant_id    = rr_ptr_reg;
        end else if (!fifo_empty[0]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (!fifo_empty[1]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign fifo_pop  = grant_valid ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign grant_cmd = head_cmd[grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wr_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            mem_id_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
        end else begin
            // Read data arrives the cycle after issue, so the response trails mem_en by one.
            rsp_valid_reg <= mem_en_reg && !mem_wr_reg;
            if (mem_en_reg && !mem_wr_reg)
                rsp_id_reg <= mem_id_reg;
            if (grant_valid) begin
                mem_en_reg    <= 1'b1;
                mem_addr_reg  <= grant_cmd.addr;
                mem_wr_reg    <= grant_cmd.wr;
                mem_wdata_reg <= grant_cmd.wdata;
                mem_id_reg    <= grant_id;
                rr_ptr_reg    <= !grant_id;
            end else begin
                mem_en_reg    <= 1'b0;
            end
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-vector table, directed corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, mem_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rsp_valid, rsp_id;
    logic [DW-1:0] rsp_data;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_wr    (req0_wr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_wr    (req1_wr),
        .req1_wdata (req1_wdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_en     (mem_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    // Memory model: reads return a known function of the address one cycle later.
    always @(posedge clk) begin
        if (mem_en && !mem_wr)
            mem_rdata <= {2'b00, mem_addr} ^ 8'hB2;
        else
            mem_rdata <= 8'($urandom);
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } tcmd_t;

    tcmd_t         q0[$];
    tcmd_t         q1[$];
    bit            m_rr;
    bit            m_en, m_wr, m_id, m_rv, m_rid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdat;
    bit            known = 1'b0;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge, from the queue contents before the edge.
    task automatic model_edge(input bit r, input bit v0, input tcmd_t c0,
                              input bit v1, input tcmd_t c1);
        bit    acc0, acc1, n0, n1, g, gv;
        tcmd_t c;
        if (r) begin
            q0.delete(); q1.delete();
            m_rr = 0; m_en = 0; m_addr = '0; m_wr = 0; m_wd = '0; m_id = 0;
            m_rv = 0; m_rid = 0;
            return;
        end
        acc0 = v0 && (q0.size() < DEPTH);
        acc1 = v1 && (q1.size() < DEPTH);
        m_rv = m_en && !m_wr;
        if (m_rv) begin
            m_rid  = m_id;
            m_rdat = {2'b00, m_addr} ^ 8'hB2;
        end
        n0 = q0.size() > 0;
        n1 = q1.size() > 0;
        gv = n0 || n1;
        g  = (n0 && n1) ? m_rr : n1 && !n0;
        if (gv) begin
            c = g ? q1.pop_front() : q0.pop_front();
            m_en = 1; m_addr = c.addr; m_wr = c.wr; m_wd = c.wdata; m_id = g;
            m_rr = !g;
        end else begin
            m_en = 0;
        end
        if (acc0) q0.push_back(c0);
        if (acc1) q1.push_back(c1);
    endtask

    task automatic step(input bit r,
                        input bit v0, input logic [AW-1:0] a0, input bit w0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input bit w1, input logic [DW-1:0] d1);
        rst = r;
        req0_valid = v0; req0_addr = a0; req0_wr = w0; req0_wdata = d0;
        req1_valid = v1; req1_addr = a1; req1_wr = w1; req1_wdata = d1;
        if (known && !r) begin
            chk("ready0", 32'(req0_ready), 32'(q0.size() < DEPTH));
            chk("ready1", 32'(req1_ready), 32'(q1.size() < DEPTH));
        end
        @(posedge clk);
        model_edge(r, v0, {a0, w0, d0}, v1, {a1, w1, d1});
        if (r) known = 1'b1;
        #1;
        cyc++;
        chk("mem_en", 32'(mem_en), 32'(m_en));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wr", 32'(mem_wr), 32'(m_wr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rsp_data", 32'(rsp_data), 32'(m_rdat));
        end
        if (m_en || m_rv)
            $display("cyc %0d issue=%0b id=%0d addr=%0d wr=%0b rsp=%0b rsp_id=%0d rsp_data=%0h",
                     cyc, m_en, m_id, m_addr, m_wr, m_rv, m_rid, m_rdat);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, '0, 0, '0, 0, '0);
        step(1, 0, '0, 0, '0, 0, '0, 0, '0);
    endtask

    typedef struct {
        bit            v0;
        logic [AW-1:0] a0;
        bit            v1;
        logic [AW-1:0] a1;
        bit            en;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Contention: expected issue order 48,12,56,14, then rr back at requester 0.
        tbl[0] = '{1, 6'd48, 1, 6'd12, 0, 6'd0};
        tbl[1] = '{1, 6'd56, 1, 6'd14, 1, 6'd48};
        tbl[2] = '{0, 6'd0,  0, 6'd0,  1, 6'd12};
        tbl[3] = '{0, 6'd0,  0, 6'd0,  1, 6'd56};
        tbl[4] = '{0, 6'd0,  0, 6'd0,  1, 6'd14};
        tbl[5] = '{0, 6'd0,  0, 6'd0,  0, 6'd14};
        tbl[6] = '{1, 6'd60, 1, 6'd30, 0, 6'd14};
        tbl[7] = '{0, 6'd0,  0, 6'd0,  1, 6'd60};
        tbl[8] = '{0, 6'd0,  0, 6'd0,  1, 6'd30};

        do_reset();
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_ready0", 32'(req0_ready), 1);
        chk("rst_ready1", 32'(req1_ready), 1);

        for (int i = 0; i < 9; i++) begin
            step(0, tbl[i].v0, tbl[i].a0, 1, DW'(tbl[i].a0 + 1),
                    tbl[i].v1, tbl[i].a1, 1, DW'(tbl[i].a1 + 1));
            chk("tbl_en", 32'(mem_en), 32'(tbl[i].en));
            chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].addr));
        end

        // Single requester: 12,14 writes then a read of 23.
        do_reset();
        step(0, 1, 6'd12, 1, 8'h11, 0, '0, 0, '0);
        chk("single_lat0", 32'(mem_en), 0);
        step(0, 1, 6'd14, 1, 8'h22, 0, '0, 0, '0);
        chk("single_en1", 32'(mem_en), 1);
        chk("single_addr1", 32'(mem_addr), 12);
        step(0, 1, 6'd23, 0, 8'h33, 0, '0, 0, '0);
        chk("single_addr2", 32'(mem_addr), 14);
        idle();
        chk("single_addr3", 32'(mem_addr), 23);
        chk("single_rd", 32'(mem_wr), 0);
        chk("single_norsp", 32'(rsp_valid), 0);
        idle();
        chk("single_rsp", 32'(rsp_valid), 1);
        chk("single_rsp_id", 32'(rsp_id), 0);
        chk("single_rsp_data", 32'(rsp_data), 32'hA5);
        chk("single_en_off", 32'(mem_en), 0);
        idle();
        chk("single_rsp_once", 32'(rsp_valid), 0);

        // Idle: mem_en stays low and the port keeps the last address.
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_en", 32'(mem_en), 0);
            chk("idle_addr", 32'(mem_addr), 23);
        end

        // Read return on requester 1.
        step(0, 0, '0, 0, '0, 1, 6'd23, 0, 8'h00);
        idle();
        chk("rd1_en", 32'(mem_en), 1);
        idle();
        chk("rd1_rsp", 32'(rsp_valid), 1);
        chk("rd1_id", 32'(rsp_id), 1);
        chk("rd1_data", 32'(rsp_data), 32'hA5);
        idle();
        chk("rd1_once", 32'(rsp_valid), 0);

        // Full: both requesters push every cycle so the queues outgrow the single drain.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) chk("full_ready1", 32'(req1_ready), 0);
            step(0, 1, AW'(i), 1, DW'(i), 1, AW'(32 + i), 1, DW'(100 + i));
        end
        for (int i = 0; i < 10; i++) idle();

        // Reset with a read in flight and three commands queued.
        do_reset();
        step(0, 1, 6'd5, 0, 8'h00, 1, 6'd9, 1, 8'h09);
        step(0, 1, 6'd6, 1, 8'h06, 1, 6'd10, 1, 8'h0A);
        chk("mid_rd_issued", 32'(mem_en && !mem_wr), 1);
        step(1, 0, '0, 0, '0, 0, '0, 0, '0);
        chk("mid_en", 32'(mem_en), 0);
        chk("mid_rsp", 32'(rsp_valid), 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("mid_no_issue", 32'(mem_en), 0);
            chk("mid_no_rsp", 32'(rsp_valid), 0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0, AW'($urandom), 1'($urandom), DW'($urandom),
                 $urandom_range(0, 2) != 0, AW'($urandom), 1'($urandom), DW'($urandom));
        end
        for (int i = 0; i < 12; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
